// File: rtl/tl_ul_test_responder.sv
// rtl/tl_ul_test_responder.sv - TL-UL responder with word memory and one-cycle response register
// Optional TL_RESP_STALL_EN adds LFSR-driven pseudo-random A-channel backpressure.
module tl_ul_test_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          SOURCE_W    = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [2:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [31:0]         a_address,
  input  logic [3:0]          a_mask,
  input  logic [31:0]         a_data,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [2:0]          d_param,
  output logic [2:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_denied,
  output logic                d_corrupt,
  output logic [31:0]         d_data
);
  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(4 * DEPTH_WORDS);

  logic                r_d_valid;
  logic [2:0]          r_d_opcode;
  logic [2:0]          r_d_size;
  logic [SOURCE_W-1:0] r_d_source;
  logic                r_d_denied;
  logic                r_d_corrupt;
  logic [31:0]         r_d_data;
  logic [31:0]         r_mem [DEPTH_WORDS];

  logic          w_stall_ok;
  logic          w_a_ready;
  logic          w_a_fire;
  logic          w_d_fire;
  logic [31:0]   w_offset;
  logic          w_in_range;
  logic          w_aligned;
  logic          w_is_put;
  logic          w_is_get;
  logic          w_legal;
  logic [AW-1:0] w_idx;
  logic          w_unused;

`ifdef TL_RESP_STALL_EN
  logic [7:0] r_lfsr;

  // Fibonacci taps 8,6,5,4; bit 0 takes the feedback each cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_lfsr <= 8'hA5;
    else       r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end
  assign w_stall_ok = ~r_lfsr[0];
`else
  assign w_stall_ok = 1'b1;
`endif

  assign w_a_ready = ~reset & (~r_d_valid | d_ready) & w_stall_ok;
  assign w_a_fire  = a_valid & w_a_ready;
  assign w_d_fire  = r_d_valid & d_ready;

  assign w_offset   = a_address - BASE_ADDR;
  assign w_in_range = (a_address >= BASE_ADDR) && ({1'b0, w_offset} < SPAN);
  assign w_idx      = w_offset[AW+1:2];
  assign w_is_put   = (a_opcode == 3'd0) || (a_opcode == 3'd1);
  assign w_is_get   = (a_opcode == 3'd4);

  // Sizes above a word fall into the default and are treated as misaligned.
  always_comb begin
    w_aligned = 1'b0;
    case (a_size)
      3'd0:    w_aligned = 1'b1;
      3'd1:    w_aligned = ~a_address[0];
      3'd2:    w_aligned = (a_address[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
  end

  assign w_legal  = (w_is_put | w_is_get) & w_aligned & w_in_range;
  assign w_unused = ^{a_param, w_offset[31:AW+2], w_offset[1:0]};

  always_ff @(posedge clock) begin
    if (w_a_fire && w_legal && w_is_put) begin
      for (int b = 0; b < 4; b++) begin
        if (a_mask[b]) r_mem[w_idx][8*b +: 8] <= a_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_d_valid   <= 1'b0;
      r_d_opcode  <= 3'd0;
      r_d_size    <= 3'd0;
      r_d_source  <= '0;
      r_d_denied  <= 1'b0;
      r_d_corrupt <= 1'b0;
      r_d_data    <= 32'd0;
    end else if (w_a_fire) begin
      r_d_valid   <= 1'b1;
      r_d_opcode  <= w_is_get ? 3'd1 : 3'd0;
      r_d_size    <= a_size;
      r_d_source  <= a_source;
      r_d_denied  <= ~w_legal;
      r_d_corrupt <= ~w_legal & w_is_get;
      r_d_data    <= (w_legal && w_is_get) ? r_mem[w_idx] : 32'd0;
    end else if (w_d_fire) begin
      r_d_valid <= 1'b0;
    end
  end

  assign a_ready   = w_a_ready;
  assign d_valid   = r_d_valid;
  assign d_opcode  = r_d_opcode;
  assign d_param   = 3'd0;
  assign d_size    = r_d_size;
  assign d_source  = r_d_source;
  assign d_denied  = r_d_denied;
  assign d_corrupt = r_d_corrupt;
  assign d_data    = r_d_data;
endmodule

// File: doc/tl_ul_test_responder.md
# tl_ul_test_responder

Single-clock TileLink-UL responder (slave) model that accepts A-channel requests and returns D-channel responses from a small internal word memory. It is the driving counterpart to the TileLink protocol monitors: it sits at the manager end of a TL-UL port in the testbench fabric and gives monitored masters a protocol-correct, deterministic target. It has one response register, one-cycle latency, full-throughput pipelining and error signalling via `d_denied`/`d_corrupt`.

## Interface
- `BASE_ADDR`, default 32'h8000_0000: byte address of memory word 0.
- `DEPTH_WORDS`, default 256: number of 32-bit words; power of two, ≥ 2.
- `SOURCE_W`, default 3: width of the source ID.
- `clock`  in  1: sole clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `a_valid`  in  1: A request valid.
- `a_ready`  out  1: responder can accept A.
- `a_opcode`  in  3: 0 PutFullData, 1 PutPartialData, 4 Get; all others unsupported.
- `a_param`  in  3: ignored; must be 0.
- `a_size`  in  3: log2 bytes.
- `a_source`  in  SOURCE_W: request ID.
- `a_address`  in  32: byte address.
- `a_mask`  in  4: byte lanes.
- `a_data`  in  32: write data.
- `d_valid`  out  1: response valid.
- `d_ready`  in  1: master accepts D.
- `d_opcode`  out  3: 0 AccessAck, 1 AccessAckData.
- `d_param`  out  3: always 0.
- `d_size`  out  3: echo of `a_size`.
- `d_source`  out  SOURCE_W: echo of `a_source`.
- `d_denied`  out  1: request rejected.
- `d_corrupt`  out  1: data invalid; set only with denied AccessAckData.
- `d_data`  out  32: read data; 0 when not AccessAckData or denied.

## Operation
- A fires when `a_valid & a_ready`. `a_ready = ~reset & (~d_valid | d_ready) & stall_ok`. `stall_ok` is 1 unless the stall feature is compiled in.
- Legality: the request is legal iff all of the following hold:
  - opcode ∈ {0,1,4};
  - `a_size` ≤ 2;
  - `a_address` is aligned to `1<<a_size`;
  - `BASE_ADDR ≤ a_address < BASE_ADDR + 4*DEPTH_WORDS`.
- Word index = `(a_address - BASE_ADDR) >> 2`, truncated to log2(DEPTH_WORDS) bits.
- Legal Put: on the fire edge, write the `a_data` byte lanes selected by `a_mask`. The response is AccessAck with denied=0.
  - PutFullData does not check mask/size consistency; the mask is applied as given.
- Legal Get: the word at the index is captured into `d_data` on the fire edge. The response is AccessAckData with denied=0, corrupt=0.
- Illegal Get: response is AccessAckData, denied=1, corrupt=1, `d_data`=0.
- Any other illegal request: response is AccessAck, denied=1, corrupt=0. Memory is unchanged.
- Response register: loaded on every A fire. `d_valid` clears on a D fire with no simultaneous A fire. On a simultaneous A and D fire, the register reloads and `d_valid` stays 1.
- D outputs are held stable while `d_valid & ~d_ready`.
- Memory contents are not reset; a Get of an unwritten word returns X in simulation.

## Timing
- Reset values: `d_valid`=0; all `d_*` fields=0; `a_ready`=0 while `reset` is high. `a_ready` is 1 on the first cycle after deassertion with the stall feature off.
- Latency: A fire in cycle N → `d_valid`=1 in cycle N+1.
- Throughput: one request per cycle while `d_ready`=1.
- Read-after-write: a Put firing in cycle N is visible to a Get firing in cycle N+1 or later.
- Backpressure: `d_ready`=0 with `d_valid`=1 forces `a_ready`=0 the same cycle; no request is lost or duplicated.
- Reset asserted mid-transaction: `d_valid` drops immediately (asynchronous); the pending response is discarded; memory keeps its contents.

## Configuration
- `TL_RESP_STALL_EN`:
  - Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'hA5) advances every cycle. `stall_ok = ~lfsr[0]`, giving pseudo-random A backpressure. The sequence is deterministic from reset.
  - Undefined: no LFSR; `stall_ok`=1.

## Test plan
- Reset then idle: `d_valid`=0 and `a_ready`=0 during reset; `a_ready`=1 the cycle after release (no stall macro).
- PutFullData addr 0x8000_0010, mask 4'hF, data 0xDEADBEEF, then Get size 2 same address back-to-back → AccessAck, then AccessAckData with data 0xDEADBEEF, in consecutive cycles.
- PutPartialData mask 4'b0101, data 0x11223344 onto 0xDEADBEEF → subsequent Get returns 0xDE22BE44.
- Get at 0x8000_0400 (out of range) with source 5 → AccessAckData, denied=1, corrupt=1, data=0, source=5. Opcode 6 request → AccessAck, denied=1, memory unchanged.
- Hold `d_ready`=0 for 3 cycles with a response pending → D fields stable, `a_ready`=0 throughout. Releasing `d_ready` with `a_valid`=1 → simultaneous fire, `d_valid` stays 1 with the new response.
- With `TL_RESP_STALL_EN`: 100 back-to-back Gets → every request gets exactly one response in order. The stall pattern matches an LFSR model seeded 8'hA5.
